// File: rtl/and16b_operand_stager_if.sv
// Handshake and array-side bus for the AND-array operand stager.
// The slave modport is the stager; the master modport is its environment
// (operand producer, result consumer and the AND array itself).
interface and16b_operand_stager_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] gate_a;
  logic [WIDTH-1:0] gate_b;
  logic [WIDTH-1:0] gate_out;
  logic             gate_en;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             clr_err;
  logic             err_flag;
  logic [7:0]       err_cnt;

  modport slave (
    input  in_valid, in_a, in_b, gate_out, res_ready, clr_err,
    output in_ready, gate_a, gate_b, gate_en, res_valid, res_data,
           err_flag, err_cnt
  );

  modport master (
    output in_valid, in_a, in_b, gate_out, res_ready, clr_err,
    input  in_ready, gate_a, gate_b, gate_en, res_valid, res_data,
           err_flag, err_cnt
  );
endinterface

// File: rtl/and16b_operand_stager.sv
// Operand stager for the 16-bit adiabatic AND array.
// IDLE -> EVAL (operands driven for SETTLE cycles) -> RTZ (operands zero for
// RECOVER cycles) -> IDLE. The array output is sampled at the end of EVAL,
// checked against the latched a&b and offered on the result handshake.
module and16b_operand_stager #(
  parameter int WIDTH   = 16,
  parameter int SETTLE  = 4,
  parameter int RECOVER = 2
) (
  input logic                   clkpos,
  input logic                   rst,
  and16b_operand_stager_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RTZ} state_t;

  // Terminal counts: EVAL/RTZ cycles are counted from 0.
  localparam logic [3:0] SETTLE_TC  = 4'(SETTLE - 1);
  localparam logic [3:0] RECOVER_TC = 4'(RECOVER - 1);

  state_t           state, nstate;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] expd;
  logic             accept;
  logic             sample;
  logic             mismatch;

  // Ready only depends on state/res_valid (and is forced low during reset).
  assign bus.in_ready = (state == IDLE) && !bus.res_valid && !rst;
  assign mismatch     = (bus.gate_out != expd);

  // State register.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state decode plus the accept/sample strobes.
  always_comb begin
    nstate = state;
    accept = 1'b0;
    sample = 1'b0;
    case (state)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        accept = 1'b1;
        nstate = EVAL;
      end
      EVAL: if (cnt == SETTLE_TC) begin
        sample = 1'b1;
        nstate = RTZ;
      end
      RTZ:  if (cnt == RECOVER_TC) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Phase counter: restarts on every state change, runs in EVAL/RTZ.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (nstate != state) cnt <= '0;
    else if (state != IDLE)   cnt <= cnt + 4'd1;
  end

  // Operand drive, sampling and result handshake.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      bus.gate_a    <= '0;
      bus.gate_b    <= '0;
      bus.gate_en   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      expd          <= '0;
    end else begin
      if (accept) begin
        bus.gate_a  <= bus.in_a;
        bus.gate_b  <= bus.in_b;
        bus.gate_en <= 1'b1;
        expd        <= bus.in_a & bus.in_b;
      end else if (sample) begin
        bus.gate_a  <= '0;
        bus.gate_b  <= '0;
        bus.gate_en <= 1'b0;
      end
      // res_valid is never high at sample time (accept needs it low).
      if (sample) begin
        bus.res_data  <= bus.gate_out;
        bus.res_valid <= 1'b1;
      end else if (bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

  // Error statistics; a mismatch on the clearing edge still counts once.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      bus.err_flag <= 1'b0;
      bus.err_cnt  <= '0;
    end else if (sample && mismatch) begin
      bus.err_flag <= 1'b1;
      if (bus.clr_err)               bus.err_cnt <= 8'd1;
      else if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end else if (bus.clr_err) begin
      bus.err_flag <= 1'b0;
      bus.err_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_and16b_operand_stager.sv
// Directed bench for the AND-array operand stager. The AND array is modelled
// behaviourally with an optional stuck-at-0 on bit 3; expected results are
// queued at operand accept and compared at the result handshake.
module tb_and16b_operand_stager;
  localparam int W = 16;

  logic clkpos = 1'b0;
  logic rst    = 1'b1;
  logic fault  = 1'b0;

  and16b_operand_stager_if #(.WIDTH(W)) bus ();

  and16b_operand_stager #(.WIDTH(W), .SETTLE(4), .RECOVER(2)) dut (
    .clkpos (clkpos),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clkpos = ~clkpos;

  // AND array model, optionally with bit 3 stuck low.
  assign bus.gate_out = bus.gate_a & bus.gate_b & (fault ? ~16'h0008 : 16'hFFFF);

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes that will happen on the coming edge, then
  // advance to the next falling edge (where outputs are sampled).
  task automatic cyc();
    logic [W-1:0] e;
    if (bus.in_valid && bus.in_ready)
      sb.push_back((bus.in_a & bus.in_b) & (fault ? ~16'h0008 : 16'hFFFF));
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 32'(bus.res_data), 32'hDEAD_BEEF);
      else begin
        e = sb.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e));
      end
    end
    @(negedge clkpos);
  endtask

  // Full operation with res_ready high; optional clr_err on the sample edge.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr_at_sample);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin cyc(); n++; end
    chk("op_ready_timeout", 32'(n < 50), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    if (clr_at_sample) bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("res_valid_at_sample", 32'(bus.res_valid), 32'd1);
    n = 0;
    while (bus.res_valid && n < 20) begin cyc(); n++; end
    chk("res_consume_timeout", 32'(n < 20), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    int n, cyc_n, last, acc;
    bit hs;

    // 1. Reset state with random inputs.
    bus.in_valid = 1'($urandom); bus.in_a = W'($urandom); bus.in_b = W'($urandom);
    bus.res_ready = 1'($urandom); bus.clr_err = 1'($urandom);
    repeat (3) @(negedge clkpos);
    chk("rst_gate_a", 32'(bus.gate_a), 0);
    chk("rst_gate_b", 32'(bus.gate_b), 0);
    chk("rst_gate_en", 32'(bus.gate_en), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_err_flag", 32'(bus.err_flag), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0; bus.clr_err = 1'b0; bus.res_ready = 1'b1;
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clkpos);

    // 2. Single operation, cycle by cycle.
    bus.in_valid = 1'b1; bus.in_a = 16'hF0F0; bus.in_b = 16'hFF00;
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("eval_gate_a", 32'(bus.gate_a), 32'hF0F0);
      chk("eval_gate_b", 32'(bus.gate_b), 32'hFF00);
      chk("eval_gate_en", 32'(bus.gate_en), 1);
      if (k < 3) cyc();
    end
    cyc();
    chk("e4_res_valid", 32'(bus.res_valid), 1);
    chk("e4_res_data", 32'(bus.res_data), 32'hF000);
    chk("e4_gate_a", 32'(bus.gate_a), 0);
    chk("e4_gate_en", 32'(bus.gate_en), 0);
    chk("e4_in_ready", 32'(bus.in_ready), 0);
    cyc();
    chk("e5_res_valid", 32'(bus.res_valid), 0);
    chk("e5_gate_b", 32'(bus.gate_b), 0);
    chk("e5_in_ready", 32'(bus.in_ready), 0);
    cyc();
    chk("e6_in_ready", 32'(bus.in_ready), 1);
    chk("single_err_cnt", 32'(bus.err_cnt), 0);

    // 3. Backpressure on the result.
    bus.res_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'hA5A5; bus.in_b = 16'h0FF0;
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    chk("bp_res_valid", 32'(bus.res_valid), 1);
    held = bus.res_data;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("bp_hold_valid", 32'(bus.res_valid), 1);
      chk("bp_hold_data", 32'(bus.res_data), 32'(held));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.res_ready = 1'b1;
    cyc();
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    chk("bp_release_valid", 32'(bus.res_valid), 0);

    // 4. Fault injection and error statistics.
    fault = 1'b1;
    op(16'hFFFF, 16'hFFFF, 1'b0);
    chk("fault_err_flag", 32'(bus.err_flag), 1);
    chk("fault_err_cnt1", 32'(bus.err_cnt), 1);
    for (int k = 0; k < 299; k++) op(16'hFFFF, 16'hFFFF, 1'b0);
    chk("fault_err_sat", 32'(bus.err_cnt), 255);
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("clr_err_cnt", 32'(bus.err_cnt), 0);
    chk("clr_err_flag", 32'(bus.err_flag), 0);
    op(16'hFFFF, 16'h00FF, 1'b0);
    op(16'hFFFF, 16'h00FF, 1'b0);
    chk("fault_err_cnt2", 32'(bus.err_cnt), 2);
    op(16'hFFFF, 16'h00FF, 1'b1);
    chk("clr_vs_event_cnt", 32'(bus.err_cnt), 1);
    chk("clr_vs_event_flag", 32'(bus.err_flag), 1);
    fault = 1'b0;
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;

    // 5. Reset in the middle of EVAL.
    bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'h5555;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("mid_gate_en_before", 32'(bus.gate_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_gate_a", 32'(bus.gate_a), 0);
    chk("mid_async_gate_b", 32'(bus.gate_b), 0);
    chk("mid_async_gate_en", 32'(bus.gate_en), 0);
    sb.delete();
    @(negedge clkpos);
    rst = 1'b0;
    #1;
    chk("mid_res_valid", 32'(bus.res_valid), 0);
    chk("mid_err_cnt", 32'(bus.err_cnt), 0);
    chk("mid_in_ready", 32'(bus.in_ready), 1);
    @(negedge clkpos);
    op(16'h1234, 16'h00FF, 1'b0);
    chk("post_mid_err_cnt", 32'(bus.err_cnt), 0);

    // 6. Back-to-back throughput.
    cyc_n = 0; last = 0; acc = 0;
    bus.in_valid = 1'b1; bus.in_a = W'($urandom); bus.in_b = W'($urandom);
    while (acc < 8 && cyc_n < 200) begin
      hs = bus.in_valid && bus.in_ready;
      cyc();
      cyc_n++;
      if (hs) begin
        if (acc > 0) chk("issue_interval", 32'(cyc_n - last), 7);
        last = cyc_n;
        acc++;
        bus.in_a = W'($urandom); bus.in_b = W'($urandom);
        if (acc == 8) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 8);
    n = 0;
    while (sb.size() != 0 && n < 50) begin cyc(); n++; end
    chk("b2b_drained", 32'(sb.size()), 0);
    chk("b2b_err_cnt", 32'(bus.err_cnt), 0);
    chk("b2b_err_flag", 32'(bus.err_flag), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/and16b_operand_stager.md
# and16b_operand_stager

Digital staging block directly upstream of the 16-bit adiabatic AND array. It takes operand pairs over a valid/ready handshake and drives them onto the array's `a`/`b` inputs for a fixed settle window. It then samples the array's `out` bus, returns the result over a second valid/ready handshake and drives the operands back to zero for a recovery window. It also checks each sampled result against the expected bitwise AND and keeps error statistics for the verification bench.

## Interface
- `WIDTH`, 16, operand/result width; matches the AND array.
- `SETTLE`, 4, cycles the operands are held before sampling; legal range 1–15.
- `RECOVER`, 2, return-to-zero cycles after sampling; legal range 1–15.

Ports:
- `clkpos`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  stager can accept an operand pair.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `gate_a`  out  WIDTH  to AND array `a`; registered.
- `gate_b`  out  WIDTH  to AND array `b`; registered.
- `gate_out`  in  WIDTH  from AND array `out`.
- `gate_en`  out  1  high while the operands are driven (EVAL).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  sampled `gate_out`.
- `clr_err`  in  1  synchronous clear of the error statistics.
- `err_flag`  out  1  sticky; set on any mismatch.
- `err_cnt`  out  8  mismatch count; saturates at 255.

## Operation
The block has three states.
- **IDLE**
  - `gate_a` = `gate_b` = 0, `gate_en` = 0.
  - `in_ready` = (state == IDLE) && !`res_valid`.
  - A handshake (`in_valid` && `in_ready`) latches `in_a`/`in_b` into `gate_a`/`gate_b` and the expected value `in_a & in_b` into an internal register. The block then enters EVAL with the cycle counter at 0.
- **EVAL**
  - Operands are held constant, `gate_en` = 1, and the counter increments every cycle.
  - On the edge that completes the SETTLE-th EVAL cycle:
    - `res_data` <= `gate_out` and `res_valid` <= 1.
    - Compare `gate_out` with the expected value.
    - `gate_a`/`gate_b` <= 0 and `gate_en` <= 0.
    - Counter resets; state goes to RTZ.
- **RTZ**
  - Operands are held at 0 for RECOVER cycles, then the state goes to IDLE.
  - The result handshake may complete during RTZ.
- **Result handshake**
  - When `res_valid` && `res_ready`, `res_valid` clears on that edge.
  - `res_data` holds its last value and is don't-care while `res_valid` = 0.
  - `res_data` and `res_valid` are stable while `res_valid` && !`res_ready`.
- **Single outstanding operation:** no new accept occurs while a result is unconsumed.
- **Error statistics**
  - A mismatch at sample time sets `err_flag` and increments `err_cnt`, saturating at 255.
  - `clr_err` zeroes both.
  - If `clr_err` and a mismatch occur on the same edge, the result is `err_cnt` = 1 and `err_flag` = 1 (the event wins).
- **Reset (`rst` high, asynchronous, at any time including mid-EVAL/RTZ)**
  - State goes to IDLE.
  - `gate_a`, `gate_b`, `gate_en`, `res_valid`, `res_data`, `err_flag` and `err_cnt` all go to 0 immediately.
  - The in-flight operation is discarded and no compare is performed.
- `in_ready` = 0 while `rst` is high.

## Timing
- Accept edge E0: `gate_a`/`gate_b`/`gate_en` are valid from E0 through E0+SETTLE.
- Sample edge E0+SETTLE: `res_valid` rises there.
- Zero-operand window: E0+SETTLE to E0+SETTLE+RECOVER.
- `in_ready` returns high after E0+SETTLE+RECOVER if the result has been consumed; otherwise it rises on the edge where the result handshake completes.
- Minimum issue interval with `res_ready` tied high and `in_valid` held high: SETTLE+RECOVER+1 cycles (7 at defaults).
- The `gate_out` sampling path is direct to a register, with no combinational path from `gate_out` to any output.
- `in_ready` is combinational from state and `res_valid` only; it never depends on `in_valid`.

## Test plan
Defaults: SETTLE = 4, RECOVER = 2. The bench models `gate_out` = `gate_a & gate_b` unless stated otherwise.
1. **Reset state:** assert `rst` with random inputs → every output is 0. After release, `in_ready` = 1 on the first cycle.
2. **Single operation:** `a` = 0xF0F0, `b` = 0xFF00 accepted at E0 → `gate_a` = 0xF0F0 and `gate_en` = 1 for 4 cycles. At E4, `res_data` = 0xF000 and `res_valid` = 1. Operands are 0 for E4–E6, `in_ready` = 1 after E6, and `err_cnt` = 0.
3. **Backpressure:** hold `res_ready` = 0 for 10 cycles after the sample → `res_data` and `res_valid` are stable and `in_ready` stays 0 after RTZ. On release, `in_ready` = 1 the cycle after the handshake.
4. **Fault injection:** force `gate_out` bit 3 to 0 with `a` = `b` = 0xFFFF → `res_data` = 0xFFF7, `err_flag` = 1, `err_cnt` = 1. After 300 such operations, `err_cnt` = 255. A `clr_err` pulse clears both; `clr_err` on a mismatch edge gives `err_cnt` = 1.
5. **Mid-operation reset:** pulse `rst` at EVAL cycle 2 → `gate_a`/`gate_b` = 0 asynchronously, `res_valid` = 0 and `err_cnt` unchanged at 0. The next operation, `a` = 0x1234, `b` = 0x00FF, returns 0x0034 normally.
6. **Back-to-back throughput:** `in_valid` held high and `res_ready` = 1 with 8 random pairs → accepts every 7 cycles, all results are correct and in order, and no mismatches are reported.
